// File: rtl/aoi21_cell_exerciser.sv
// aoi21_cell_exerciser: drives Gray-coded vectors into an AOI21 cell, checks QN, counts errors and toggles
// Ports:
//   CLK, RSTB      clock (rising edge), asynchronous active-low reset
//   START, REPEAT  run request (sampled in IDLE) and pass count (0 means 1)
//   IN1..IN3       registered cell inputs; QN is the cell output read back
//   BUSY, DONE     run in progress / one-cycle end-of-run pulse
//   PASS           no mismatches in the last run, held until the next START accept
//   ERR_CNT        saturating mismatch count
//   TOG_CNT        saturating count of QN changes between consecutive samples
module aoi21_cell_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT_W      = 8
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                START,
    input  logic [REPEAT_W-1:0] REPEAT,
    output logic                IN1,
    output logic                IN2,
    output logic                IN3,
    input  logic                QN,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [7:0]          ERR_CNT,
    output logic [15:0]         TOG_CNT
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] APPLY  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    logic [2:0]          state;
    logic [2:0]          idx;
    logic [2:0]          vec;
    logic [REPEAT_W-1:0] reps;
    logic [REPEAT_W-1:0] pass_cnt;
    logic [SW-1:0]       settle;
    logic                first;
    logic                prev;
    logic                exp_qn;
    logic                last;
    logic [7:0]          err_nxt;

    // Binary-to-Gray gives the single-input-toggle order 000,001,011,010,110,111,101,100
    assign vec     = idx ^ (idx >> 1);
    assign exp_qn  = ~((vec[2] & vec[1]) | vec[0]);
    assign last    = (idx == 3'd7) && (pass_cnt == reps - REPEAT_W'(1));
    assign err_nxt = (QN != exp_qn && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
    assign BUSY    = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
    assign DONE    = (state == FINISH);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= IDLE;
            idx      <= '0;
            reps     <= '0;
            pass_cnt <= '0;
            settle   <= '0;
            first    <= 1'b0;
            prev     <= 1'b0;
            IN1      <= 1'b0;
            IN2      <= 1'b0;
            IN3      <= 1'b0;
            PASS     <= 1'b0;
            ERR_CNT  <= '0;
            TOG_CNT  <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    reps     <= (REPEAT == '0) ? REPEAT_W'(1) : REPEAT;
                    idx      <= '0;
                    pass_cnt <= '0;
                    first    <= 1'b1;
                    PASS     <= 1'b0;
                    ERR_CNT  <= '0;
                    TOG_CNT  <= '0;
                    state    <= APPLY;
                end
                APPLY: begin
                    {IN1, IN2, IN3} <= vec;
                    settle          <= '0;
                    state           <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    settle <= settle + SW'(1);
                    state  <= (settle == SET_LAST) ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    ERR_CNT <= err_nxt;
                    if (!first && QN != prev && TOG_CNT != 16'hFFFF)
                        TOG_CNT <= TOG_CNT + 16'd1;
                    prev     <= QN;
                    first    <= 1'b0;
                    idx      <= idx + 3'd1;
                    pass_cnt <= (idx == 3'd7) ? pass_cnt + REPEAT_W'(1) : pass_cnt;
                    // PASS is resolved with the final sample's error update folded in
                    if (last)
                        PASS <= (err_nxt == 8'd0);
                    state <= last ? FINISH : APPLY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aoi21_cell_exerciser.sv
// tb_aoi21_cell_exerciser: directed checks of the AOI21 exerciser with ideal, stuck and inverted cells
module tb_aoi21_cell_exerciser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start0;
    logic [7:0]  rep, rep0;
    logic        in1, in2, in3, a0, b0, c0;
    logic        qn, qn0;
    logic        busy, done, pass, busy0, done0, pass0;
    logic [7:0]  err, err0;
    logic [15:0] tog, tog0;
    logic [1:0]  mode;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc;
    logic        busy_first;
    logic [2:0]  gray [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    always #5 clk = ~clk;

    // Cell model: 0 ideal, 1 stuck at 0, 2 inverted
    assign qn  = (mode == 2'd0) ? ~((in1 & in2) | in3) : (mode == 2'd1) ? 1'b0 : ((in1 & in2) | in3);
    assign qn0 = ~((a0 & b0) | c0);

    aoi21_cell_exerciser #(.SETTLE_CYCLES(2), .REPEAT_W(8)) u_dut (
        .CLK(clk), .RSTB(rst_n), .START(start), .REPEAT(rep),
        .IN1(in1), .IN2(in2), .IN3(in3), .QN(qn),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err), .TOG_CNT(tog)
    );

    aoi21_cell_exerciser #(.SETTLE_CYCLES(0), .REPEAT_W(8)) u_dut0 (
        .CLK(clk), .RSTB(rst_n), .START(start0), .REPEAT(rep0),
        .IN1(a0), .IN2(b0), .IN3(c0), .QN(qn0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .TOG_CNT(tog0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Starts a run on u_dut; cycles counted from the accept edge to the cycle DONE is seen.
    // pulse_at re-asserts START for one cycle mid-run; abort_at returns early at that cycle.
    task automatic run(input logic [7:0] r, input int pulse_at, input int abort_at, output int c);
        c = -1;
        @(negedge clk);
        start = 1'b1;
        rep   = r;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        busy_first = busy;
        for (int n = 1; n <= 20000; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == pulse_at) start = 1'b1;
            if (n == pulse_at + 1) start = 1'b0;
            if (n == abort_at || done) begin
                c = n;
                break;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        rep    = 8'd0;
        rep0   = 8'd0;
        mode   = 2'd0;
        #1;
        chk("rst_in", {29'd0, in1, in2, in3}, 32'd0);
        chk("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
        chk("rst_err", {24'd0, err}, 32'd0);
        chk("rst_tog", {16'd0, tog}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_run", {31'd0, busy}, 32'd0);

        // 1: ideal cell, 3 passes
        run(8'd3, -1, -1, cyc);
        chk("s1_cycles", cyc, 32'd96);
        chk("s1_busy_after_accept", {31'd0, busy_first}, 32'd1);
        chk("s1_busy_in_finish", {31'd0, busy}, 32'd0);
        chk("s1_err", {24'd0, err}, 32'd0);
        chk("s1_tog", {16'd0, tog}, 32'd12);
        chk("s1_pass", {31'd0, pass}, 32'd1);
        @(negedge clk);
        chk("s1_done_pulse", {31'd0, done}, 32'd0);
        chk("s1_pass_held", {31'd0, pass}, 32'd1);
        chk("s1_in_hold", {29'd0, in1, in2, in3}, 32'd4);

        // 2: QN stuck at 0, 2 passes
        mode = 2'd1;
        run(8'd2, -1, -1, cyc);
        chk("s2_cycles", cyc, 32'd64);
        chk("s2_err", {24'd0, err}, 32'd6);
        chk("s2_tog", {16'd0, tog}, 32'd0);
        chk("s2_pass", {31'd0, pass}, 32'd0);

        // 3: inverted cell, 40 passes, error count saturates
        mode = 2'd2;
        run(8'd40, -1, -1, cyc);
        chk("s3_cycles", cyc, 32'd1280);
        chk("s3_err_sat", {24'd0, err}, 32'd255);
        chk("s3_tog", {16'd0, tog}, 32'd160);
        chk("s3_pass", {31'd0, pass}, 32'd0);

        // 4: zero settle, REPEAT=0 treated as one pass, IN trace in Gray order
        @(negedge clk);
        start0 = 1'b1;
        rep0   = 8'd0;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        cyc    = -1;
        chk("s4_in_0", {29'd0, a0, b0, c0}, {29'd0, gray[0]});
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n % 2 == 1 && n <= 15) chk("s4_in_trace", {29'd0, a0, b0, c0}, {29'd0, gray[(n - 1) / 2]});
            if (done0) begin
                cyc = n;
                break;
            end
        end
        chk("s4_cycles", cyc, 32'd16);
        chk("s4_err", {24'd0, err0}, 32'd0);
        chk("s4_tog", {16'd0, tog0}, 32'd4);
        chk("s4_pass", {31'd0, pass0}, 32'd1);

        // 5: START pulsed mid-run is ignored
        mode = 2'd0;
        run(8'd3, 10, -1, cyc);
        chk("s5_cycles", cyc, 32'd96);
        chk("s5_err", {24'd0, err}, 32'd0);
        chk("s5_tog", {16'd0, tog}, 32'd12);
        chk("s5_pass", {31'd0, pass}, 32'd1);
        repeat (3) @(negedge clk);
        chk("s5_no_restart", {31'd0, busy}, 32'd0);

        // 6: reset during SETTLE of idx 4, then a clean run
        mode = 2'd1;
        run(8'd3, -1, 17, cyc);
        chk("s6_pre_in", {29'd0, in1, in2, in3}, 32'd6);
        chk("s6_pre_err", {24'd0, err}, 32'd2);
        chk("s6_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_in", {29'd0, in1, in2, in3}, 32'd0);
        chk("s6_rst_flags", {29'd0, busy, done, pass}, 32'd0);
        chk("s6_rst_err", {24'd0, err}, 32'd0);
        chk("s6_rst_tog", {16'd0, tog}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_no_resume", {29'd0, busy, in1, in2}, 32'd0);
        mode = 2'd0;
        run(8'd3, -1, -1, cyc);
        chk("s6_cycles", cyc, 32'd96);
        chk("s6_err", {24'd0, err}, 32'd0);
        chk("s6_tog", {16'd0, tog}, 32'd12);
        chk("s6_pass", {31'd0, pass}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
